// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe
//  Purpose  : RISC-V immediate generator (XLEN 32/64) with a registered
//             valid/ready output stage and a 2-entry skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruction_bus_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [XLEN-1:0]  Immediate_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             valid_o,
    input  logic             ready_i
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam bit       c_is64     = (XLEN == 64);
    localparam logic [2:0] c_fmt_none  = 3'd0;
    localparam logic [2:0] c_fmt_i     = 3'd1;
    localparam logic [2:0] c_fmt_s     = 3'd2;
    localparam logic [2:0] c_fmt_b     = 3'd3;
    localparam logic [2:0] c_fmt_u     = 3'd4;
    localparam logic [2:0] c_fmt_j     = 3'd5;
    localparam logic [2:0] c_fmt_zimm  = 3'd6;
    localparam logic [2:0] c_fmt_shamt = 3'd7;
    localparam int       c_pw       = XLEN + 3 + 1 + TAG_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic [31:0]     w_ins;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_shamt, w_shamt_w, w_zimm;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [c_pw-1:0] w_dec_word;

    assign w_ins    = Instruction_bus_i;
    assign w_opcode = w_ins[6:0];
    assign w_funct3 = w_ins[14:12];

    assign w_imm_i   = XLEN'($signed(w_ins[31:20]));
    assign w_imm_s   = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
    assign w_imm_b   = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}));
    assign w_imm_u   = XLEN'($signed({w_ins[31:12], 12'b0}));
    assign w_imm_j   = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));
    assign w_shamt   = c_is64 ? XLEN'(w_ins[25:20]) : XLEN'(w_ins[24:20]);
    assign w_shamt_w = XLEN'(w_ins[24:20]);
    assign w_zimm    = XLEN'(w_ins[19:15]);

    // Every recognised opcode ends in 2'b11, so compressed encodings fall to default.
    always_comb begin
        w_imm     = '0;
        w_fmt     = c_fmt_none;
        w_illegal = 1'b0;
        case (w_opcode)
            7'h03, 7'h67: begin w_imm = w_imm_i; w_fmt = c_fmt_i; end
            7'h13: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_imm = w_shamt;
                    w_fmt = c_fmt_shamt;
                end else begin
                    w_imm = w_imm_i;
                    w_fmt = c_fmt_i;
                end
            end
            7'h1B: begin
                if (!c_is64) begin
                    w_illegal = 1'b1;
                end else if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_imm = w_shamt_w;
                    w_fmt = c_fmt_shamt;
                end else begin
                    w_imm = w_imm_i;
                    w_fmt = c_fmt_i;
                end
            end
            7'h23:        begin w_imm = w_imm_s; w_fmt = c_fmt_s; end
            7'h63:        begin w_imm = w_imm_b; w_fmt = c_fmt_b; end
            7'h37, 7'h17: begin w_imm = w_imm_u; w_fmt = c_fmt_u; end
            7'h6F:        begin w_imm = w_imm_j; w_fmt = c_fmt_j; end
            7'h73: begin
                if (w_funct3[2]) begin
                    w_imm = w_zimm;
                    w_fmt = c_fmt_zimm;
                end
            end
            7'h33, 7'h0F: w_illegal = 1'b0;
            7'h3B:        w_illegal = !c_is64;
            default:      w_illegal = 1'b1;
        endcase
    end

    assign w_dec_word = {w_imm, w_fmt, w_illegal, tag_i};

    state_t          r_state, w_state_nxt;
    logic            r_ready;
    logic [c_pw-1:0] r_out, r_skid;
    logic            w_accept, w_drain;
    logic            w_load_out_in, w_load_out_skid, w_load_skid;

    assign w_accept = valid_i & r_ready;
    assign w_drain  = (r_state != ST_EMPTY) & ready_i;

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_drain) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (!w_accept && w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept && w_drain) begin
                    w_load_out_in = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // ready is registered from the next state so ready_i never reaches ready_o.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_TWO);
            if (w_load_out_in)
                r_out <= w_dec_word;
            else if (w_load_out_skid)
                r_out <= r_skid;
            if (w_load_skid)
                r_skid <= w_dec_word;
        end
    end

    assign ready_o     = r_ready;
    assign valid_o     = (r_state != ST_EMPTY);
    assign Immediate_o = r_out[c_pw-1 -: XLEN];
    assign fmt_o       = r_out[TAG_W+3 -: 3];
    assign illegal_o   = r_out[TAG_W];
    assign tag_o       = r_out[TAG_W-1:0];

endmodule
`default_nettype wire
